// File: rtl/regfile_opstage_if.sv
// Operand-fetch bus between the pipeline control side and regfile_opstage.
// master drives addresses/write-back/requests; slave returns operands and WB_DATA.
interface regfile_opstage_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
);
  logic [AW-1:0]    AA;
  logic [AW-1:0]    BA;
  logic [AW-1:0]    DA;
  logic             RW;
  logic             MD;
  logic [WIDTH-1:0] D_IN;
  logic [WIDTH-1:0] DATA_IN;
  logic             MB;
  logic [WIDTH-1:0] CONST_IN;
  logic             VALID_IN;
  logic             HOLD;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             VALID_OUT;
  logic [WIDTH-1:0] WB_DATA;

  modport master (
    output AA, BA, DA, RW, MD, D_IN, DATA_IN, MB, CONST_IN, VALID_IN, HOLD,
    input  A, B, VALID_OUT, WB_DATA
  );

  modport slave (
    input  AA, BA, DA, RW, MD, D_IN, DATA_IN, MB, CONST_IN, VALID_IN, HOLD,
    output A, B, VALID_OUT, WB_DATA
  );
endinterface

// File: rtl/regfile_opstage.sv
// Register file + operand stage feeding funcunit, with same-cycle write forwarding.
// Optional macro REGFILE_R0_ZERO_EN hard-wires R0 to zero (writes dropped, reads return 0).
module regfile_opstage #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int AW    = 3
) (
  input  logic               CLK,
  input  logic               RESET,
  regfile_opstage_if.slave   bus
);

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] wb_data;
  logic             we;
  logic             a_is_r0;
  logic             b_is_r0;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             valid_q, valid_d;

  assign wb_data     = bus.MD ? bus.DATA_IN : bus.D_IN;
  assign bus.WB_DATA = wb_data;

  // R0 writes are discarded entirely when R0 is hard-wired, so regs_q[0] never leaves 0.
  assign we      = bus.RW && !(R0_ZERO && (bus.DA == '0));
  assign a_is_r0 = R0_ZERO && (bus.AA == '0);
  assign b_is_r0 = R0_ZERO && (bus.BA == '0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[bus.DA] <= wb_data;
    end
  end

  always_comb begin
    rd_a = regs_q[bus.AA];
    rd_b = regs_q[bus.BA];
    if (bus.RW && (bus.DA == bus.AA)) rd_a = wb_data;
    if (bus.RW && (bus.DA == bus.BA)) rd_b = wb_data;
    if (a_is_r0) rd_a = '0;
    if (b_is_r0) rd_b = '0;
    b_sel = bus.MB ? bus.CONST_IN : rd_b;
  end

  // Operands refresh every non-stalled cycle; VALID_OUT alone says whether they matter.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    if (!bus.HOLD) begin
      a_d     = rd_a;
      b_d     = b_sel;
      valid_d = bus.VALID_IN;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
    end
  end

  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.VALID_OUT = valid_q;

endmodule

// File: tb/tb_regfile_opstage.sv
// Directed + short random bench for regfile_opstage with an expected-result queue.
module tb_regfile_opstage;

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        v;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [15:0] m [8];
  exp_t        cur;
  exp_t        exp_q [$];
  string       tag_q [$];

  regfile_opstage_if #(.WIDTH(16), .AW(3)) bus ();

  regfile_opstage #(.WIDTH(16), .NREG(8), .AW(3)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m[i] = 16'h0000;
    cur = '0;
  endtask

  task automatic step(input string tag,
                      input logic [2:0] aa, input logic [2:0] ba, input logic [2:0] da,
                      input logic rw, input logic md,
                      input logic [15:0] d, input logic [15:0] data,
                      input logic mb, input logic [15:0] c,
                      input logic vin, input logic hold);
    logic [15:0] wb, ra, rb;
    exp_t        e;
    string       t;
    @(negedge clk);
    bus.AA = aa; bus.BA = ba; bus.DA = da; bus.RW = rw; bus.MD = md;
    bus.D_IN = d; bus.DATA_IN = data; bus.MB = mb; bus.CONST_IN = c;
    bus.VALID_IN = vin; bus.HOLD = hold;
    wb = md ? data : d;
    ra = (rw && da == aa) ? wb : m[aa];
    rb = (rw && da == ba) ? wb : m[ba];
    if (R0Z && aa == 3'd0) ra = 16'h0000;
    if (R0Z && ba == 3'd0) rb = 16'h0000;
    if (!hold) begin
      cur.a = ra;
      cur.b = mb ? c : rb;
      cur.v = vin;
    end
    exp_q.push_back(cur);
    tag_q.push_back(tag);
    if (rw && !(R0Z && da == 3'd0)) m[da] = wb;
    #1;
    chk({tag, ".wb"}, bus.WB_DATA, wb);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk({t, ".A"}, bus.A, e.a);
    chk({t, ".B"}, bus.B, e.b);
    chk({t, ".V"}, {15'd0, bus.VALID_OUT}, {15'd0, e.v});
    $display("step %-10s A=%h B=%h V=%0b", t, bus.A, bus.B, bus.VALID_OUT);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.AA = '0; bus.BA = '0; bus.DA = '0; bus.RW = 1'b0; bus.MD = 1'b0;
    bus.D_IN = '0; bus.DATA_IN = '0; bus.MB = 1'b0; bus.CONST_IN = '0;
    bus.VALID_IN = 1'b0; bus.HOLD = 1'b0;
    model_reset();
    rst = 1'b1;
    #1;
    chk("por.A", bus.A, 16'h0000);
    chk("por.B", bus.B, 16'h0000);
    chk("por.V", {15'd0, bus.VALID_OUT}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // load R3, capture it, then reset asynchronously mid-cycle
    step("ld_r3",  3'd0, 3'd0, 3'd3, 1'b1, 1'b0, 16'h1234, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    step("rd_r3",  3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 16'h0,    16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.A", bus.A, 16'h0000);
    chk("arst.B", bus.B, 16'h0000);
    chk("arst.V", {15'd0, bus.VALID_OUT}, 16'h0000);
    bus.RW = 1'b1; bus.DA = 3'd3; bus.D_IN = 16'h5555; bus.VALID_IN = 1'b1; bus.AA = 3'd3;
    model_reset();
    @(posedge clk);
    #1;
    chk("rsthold.A", bus.A, 16'h0000);
    chk("rsthold.V", {15'd0, bus.VALID_OUT}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    bus.RW = 1'b0;
    step("post_rst", 3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);

    // plain write then read
    step("wr_r5",  3'd0, 3'd0, 3'd5, 1'b1, 1'b0, 16'hBEEF, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    step("rd_r5",  3'd5, 3'd5, 3'd0, 1'b0, 1'b0, 16'h0,    16'h0, 1'b0, 16'h0, 1'b1, 1'b0);

    // forwarding from memory data
    step("wr_r2",  3'd0, 3'd0, 3'd2, 1'b1, 1'b0, 16'h0001, 16'h0,    1'b0, 16'h0, 1'b0, 1'b0);
    step("fwd_r2", 3'd2, 3'd2, 3'd2, 1'b1, 1'b1, 16'h9999, 16'h00FF, 1'b0, 16'h0, 1'b1, 1'b0);

    // constant overrides B forwarding
    step("const",  3'd1, 3'd4, 3'd4, 1'b1, 1'b0, 16'hAAAA, 16'h0, 1'b1, 16'h0007, 1'b1, 1'b0);
    step("rd_r4",  3'd4, 3'd4, 3'd0, 1'b0, 1'b0, 16'h0,    16'h0, 1'b0, 16'h0007, 1'b1, 1'b0);

    // stall while the held operand's register is rewritten
    step("wr_r6",  3'd0, 3'd0, 3'd6, 1'b1, 1'b0, 16'h1111, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    step("cap_r6", 3'd6, 3'd6, 3'd0, 1'b0, 1'b0, 16'h0,    16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step("hold",  3'd6, 3'd6, 3'd6, 1'b1, 1'b0, 16'h2222, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    step("unhold", 3'd6, 3'd6, 3'd0, 1'b0, 1'b0, 16'h0,    16'h0, 1'b0, 16'h0, 1'b1, 1'b0);

    // R0 write with same-cycle read
    step("r0_wr",  3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 16'hFFFF, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    step("r0_rd",  3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0,    16'h0, 1'b0, 16'h0, 1'b1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      step("rand",
           3'($urandom_range(7)), 3'($urandom_range(7)), 3'($urandom_range(7)),
           1'($urandom_range(1)), 1'($urandom_range(1)),
           16'($urandom), 16'($urandom),
           1'($urandom_range(3) == 0), 16'($urandom),
           1'($urandom_range(1)), 1'($urandom_range(3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_opstage.md
Name: regfile_opstage

Overview:
- Operand-fetch stage directly upstream of the function unit.
- Holds an 8 x 16-bit register file with two read ports and registers the selected operands onto the A and B buses that feed funcunit.
- Accepts write-back from the function unit result D or from memory data, selected by MD.
- Forwards same-cycle write data to the read ports, so back-to-back dependent operations see fresh values.

Parameters:
WIDTH, 16, datapath width of registers, A, B, D_IN, DATA_IN, CONST_IN
NREG, 8, number of registers
AW, 3, register address width; NREG must equal 2**AW

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  asynchronous active-high reset
AA  input  AW  read address, A port
BA  input  AW  read address, B port
DA  input  AW  write-back destination address
RW  input  1  write enable for write-back
MD  input  1  write-back source select: 0 = D_IN, 1 = DATA_IN
D_IN  input  WIDTH  function unit result
DATA_IN  input  WIDTH  memory read data
MB  input  1  B source select: 0 = R[BA], 1 = CONST_IN
CONST_IN  input  WIDTH  immediate constant
VALID_IN  input  1  operand request this cycle
HOLD  input  1  stall: freeze A, B, VALID_OUT
A  output  WIDTH  registered A operand to funcunit
B  output  WIDTH  registered B operand to funcunit
VALID_OUT  output  1  A/B hold operands of an accepted request
WB_DATA  output  WIDTH  combinational write-back mux value (MD ? DATA_IN : D_IN)

Behaviour:
- Reset (async, RESET=1):
  - All NREG registers clear to 0.
  - A, B and VALID_OUT clear to 0 immediately, without waiting for CLK.
  - While RESET is held, writes are ignored and outputs stay 0.
- Write-back:
  - WB_DATA = MD ? DATA_IN : D_IN.
  - On a rising edge with RW=1 and RESET=0, R[DA] <= WB_DATA.
  - RW=0 leaves every register unchanged.
- Read / forwarding:
  - rdA = (RW && DA==AA) ? WB_DATA : R[AA].
  - rdB = (RW && DA==BA) ? WB_DATA : R[BA].
  - Bsel = MB ? CONST_IN : rdB. No forwarding applies to CONST_IN.
- Operand stage:
  - On a rising edge with HOLD=0: A <= rdA, B <= Bsel, VALID_OUT <= VALID_IN.
  - Latency is 1 cycle from address presentation to A/B.
  - A and B update every non-HOLD cycle regardless of VALID_IN. VALID_OUT qualifies them.
- Stall:
  - HOLD=1 freezes A, B and VALID_OUT.
  - Write-back still proceeds during HOLD.
  - Held operands are not refreshed by a write that occurs during HOLD; they keep their captured values.
- Simultaneous events:
  - AA==BA==DA with RW=1: both ports receive WB_DATA.
  - MB=1 overrides the B forwarding path.
- Wrap / range: addresses are AW bits wide, so every code is a valid register and no out-of-range case exists.
- No FSM beyond the VALID_OUT/HOLD pipeline register. The register array is plain flops with no internal reset sequencing.

Optional Feature:
- Macro: REGFILE_R0_ZERO_EN.
- Defined:
  - R0 is hard-wired to 0.
  - Writes to DA=0 are discarded.
  - Reads of address 0 return 0, including on the forwarding path, so a write to R0 with AA=0 still yields A=0.
- Undefined: R0 is an ordinary register, identical to R1..R7.

Test Plan:
- Reset: assert RESET mid-cycle after loading R3=16'h1234 -> A, B, VALID_OUT drop to 0 before the next edge; after release, read AA=3 -> A=16'h0000.
- Write/read: RW=1, DA=5, MD=0, D_IN=16'hBEEF; next cycle AA=5, BA=5, MB=0 -> one edge later A=B=16'hBEEF, VALID_OUT follows VALID_IN.
- Forwarding: R2=16'h0001; same edge RW=1, DA=2, MD=1, DATA_IN=16'h00FF, AA=2 -> A=16'h00FF (not 16'h0001).
- Constant select: MB=1, CONST_IN=16'h0007, BA=DA=4, RW=1, D_IN=16'hAAAA -> B=16'h0007; R4 subsequently reads 16'hAAAA.
- Stall: capture A=16'h1111, then HOLD=1 for 3 cycles while writing R[AA]=16'h2222 -> A stays 16'h1111; first edge after HOLD=0 gives A=16'h2222.
- R0 (with REGFILE_R0_ZERO_EN): write DA=0, D_IN=16'hFFFF with AA=0 -> A=16'h0000 that cycle and after; without macro -> A=16'hFFFF.
